// File: rtl/hub75_column_driver_pkg.sv
// ============================================================================
// Module : hub75_column_driver_pkg
// Brief  : Shared types and helpers for the HUB75 column driver.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub75_column_driver_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHOW  = 3'd4
  } state_t;

  // Colour channel positions inside a pixel word {R,G,B}, B at the LSBs.
  localparam int C_CH_B = 0;
  localparam int C_CH_G = 1;
  localparam int C_CH_R = 2;

  function automatic int planes_of(input int rgb_res);
    return rgb_res / 3;
  endfunction

  function automatic int plane_w(input int rgb_res);
    return (rgb_res / 3 > 1) ? $clog2(rgb_res / 3) : 1;
  endfunction

  function automatic int ch_lsb(input int ch, input int rgb_res);
    return ch * (rgb_res / 3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hub75_column_driver_if.sv
// ============================================================================
// Module : hub75_column_driver_if
// Brief  : Column-pair stream between frame manager (master) and driver (slave).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hub75_column_driver_if #(
  parameter int NUM_ROWS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int RGB_RES   = 9
);

  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;
  logic [$clog2(SCAN_RATE)-1:0]          col_num1;
  logic                                  data_valid;
  logic                                  hub75_ready;

  modport master (
    output columns,
    output col_num1,
    output data_valid,
    input  hub75_ready
  );

  modport slave (
    input  columns,
    input  col_num1,
    input  data_valid,
    output hub75_ready
  );

endinterface

`default_nettype wire

// File: rtl/hub75_column_driver_shifter.sv
// ============================================================================
// Module : hub75_column_driver_shifter
// Brief  : Active column buffer and serialiser producing per-plane RGB bits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_column_driver_shifter
  import hub75_column_driver_pkg::*;
#(
  parameter int NUM_ROWS = 64,
  parameter int RGB_RES  = 9
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic                                  i_start,
  input  wire logic                                  i_load,
  input  wire logic                                  i_run,
  input  wire logic [plane_w(RGB_RES)-1:0]           i_plane,
  input  wire logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] i_cols,
  output logic      [5:0]                            o_rgb,
  output logic                                       o_hub_clk,
  output logic                                       o_done
);

  localparam int PLANES = planes_of(RGB_RES);
  localparam int PW     = plane_w(RGB_RES);
  localparam int AW     = $clog2(NUM_ROWS);
  localparam int R_LSB  = ch_lsb(C_CH_R, RGB_RES);
  localparam int G_LSB  = ch_lsb(C_CH_G, RGB_RES);
  localparam int B_LSB  = ch_lsb(C_CH_B, RGB_RES);

  localparam logic [AW-1:0] C_LAST     = AW'(NUM_ROWS - 1);
  localparam logic [AW:0]   C_LAST_CNT = (AW+1)'(NUM_ROWS - 1);

  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_act;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] w_buf;
  logic [AW:0]                           r_pix;
  logic                                  r_phase;
  logic [AW:0]                           w_pix_inc;
  logic [AW-1:0]                         w_idx;
  logic [RGB_RES-1:0]                    w_px0;
  logic [RGB_RES-1:0]                    w_px1;
  logic [5:0]                            w_bits;

  function automatic logic [2:0] rgb_bits(input logic [RGB_RES-1:0] px,
                                          input logic [PW-1:0]      pl);
    logic [PLANES-1:0] r;
    logic [PLANES-1:0] g;
    logic [PLANES-1:0] b;
    r = px[R_LSB +: PLANES];
    g = px[G_LSB +: PLANES];
    b = px[B_LSB +: PLANES];
    return {r[pl], g[pl], b[pl]};
  endfunction

  assign o_done    = i_run & r_phase & (r_pix == C_LAST_CNT);
  assign w_pix_inc = r_pix + (AW+1)'(1);

  // Outputs are computed one cycle ahead so they line up with the FSM state;
  // a load edge reads the incoming pending buffer directly.
  assign w_buf  = i_load ? i_cols : r_act;
  assign w_idx  = i_start ? C_LAST : (C_LAST - w_pix_inc[AW-1:0]);
  assign w_px0  = w_buf[0][w_idx];
  assign w_px1  = w_buf[1][w_idx];
  assign w_bits = {rgb_bits(w_px0, i_plane), rgb_bits(w_px1, i_plane)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act     <= '0;
      r_pix     <= '0;
      r_phase   <= 1'b0;
      o_rgb     <= '0;
      o_hub_clk <= 1'b0;
    end else begin
      if (i_load) begin
        r_act <= i_cols;
      end
      if (i_start) begin
        r_pix     <= '0;
        r_phase   <= 1'b0;
        o_hub_clk <= 1'b0;
        o_rgb     <= w_bits;
      end else if (i_run && !o_done) begin
        if (!r_phase) begin
          r_phase   <= 1'b1;
          o_hub_clk <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_pix     <= w_pix_inc;
          o_hub_clk <= 1'b0;
          o_rgb     <= w_bits;
        end
      end else begin
        r_pix     <= '0;
        r_phase   <= 1'b0;
        o_hub_clk <= 1'b0;
        o_rgb     <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hub75_column_driver.sv
// ============================================================================
// Module : hub75_column_driver
// Brief  : Fetches column pairs and drives a 1:SCAN_RATE HUB75 panel with BCM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_column_driver
  import hub75_column_driver_pkg::*;
#(
  parameter int NUM_ROWS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int RGB_RES   = 9,
  parameter int BCM_BASE  = 4
) (
  input  wire logic                         clk_in,
  input  wire logic                         rst_in,
  hub75_column_driver_if.slave              stream,
  output logic                              hub_r0,
  output logic                              hub_g0,
  output logic                              hub_b0,
  output logic                              hub_r1,
  output logic                              hub_g1,
  output logic                              hub_b1,
  output logic                              hub_clk,
  output logic                              hub_lat,
  output logic                              hub_oe,
  output logic [$clog2(SCAN_RATE)-1:0]      hub_addr
);

  localparam int PLANES = planes_of(RGB_RES);
  localparam int PW     = plane_w(RGB_RES);
  localparam int AW     = $clog2(SCAN_RATE);
  localparam int BW     = $clog2((BCM_BASE << (PLANES - 1)) + 1);

  localparam logic [PW-1:0] C_LAST_PLANE = PW'(PLANES - 1);

  state_t                                r_state;
  logic                                  r_ready;
  logic                                  r_lat;
  logic                                  r_oe;
  logic [AW-1:0]                         r_addr;
  logic [AW-1:0]                         r_act_addr;
  logic [AW-1:0]                         r_pend_addr;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_pend_cols;
  logic                                  r_pv;
  logic [PW-1:0]                         r_plane;
  logic [PW-1:0]                         w_plane_nxt;
  logic [BW-1:0]                         r_bcm;
  logic [BW-1:0]                         w_len;
  logic                                  w_last_plane;
  logic                                  w_bcm_end;
  logic                                  w_consume;
  logic                                  w_start;
  logic                                  w_shift_done;
  logic [5:0]                            w_rgb;
  logic                                  w_hub_clk;

  assign w_len        = BW'(BCM_BASE) << r_plane;
  assign w_last_plane = (r_plane == C_LAST_PLANE);
  assign w_bcm_end    = (r_state == ST_SHOW) && (r_bcm == w_len);
  assign w_consume    = r_pv && ((r_state == ST_WAIT) || (w_bcm_end && w_last_plane));
  assign w_start      = w_consume || (w_bcm_end && !w_last_plane);
  assign w_plane_nxt  = w_consume ? '0 :
                        (w_bcm_end ? (r_plane + PW'(1)) : r_plane);

  hub75_column_driver_shifter #(
    .NUM_ROWS (NUM_ROWS),
    .RGB_RES  (RGB_RES)
  ) u_shifter (
    .clk       (clk_in),
    .rst       (rst_in),
    .i_start   (w_start),
    .i_load    (w_consume),
    .i_run     (r_state == ST_SHIFT),
    .i_plane   (w_plane_nxt),
    .i_cols    (r_pend_cols),
    .o_rgb     (w_rgb),
    .o_hub_clk (w_hub_clk),
    .o_done    (w_shift_done)
  );

  // Latest data_valid wins; a simultaneous consume still sees the old pending.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pend_cols <= '0;
      r_pend_addr <= '0;
      r_act_addr  <= '0;
      r_pv        <= 1'b0;
    end else begin
      if (w_consume) begin
        r_act_addr <= r_pend_addr;
      end
      if (stream.data_valid) begin
        r_pend_cols <= stream.columns;
        r_pend_addr <= stream.col_num1;
        r_pv        <= 1'b1;
      end else if (w_consume) begin
        r_pv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_REQ;
      r_ready <= 1'b0;
      r_lat   <= 1'b0;
      r_oe    <= 1'b1;
      r_addr  <= '0;
      r_plane <= '0;
      r_bcm   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_lat   <= 1'b0;
      r_plane <= w_plane_nxt;
      case (r_state)
        ST_REQ: begin
          r_ready <= ~r_pv;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_oe <= 1'b1;
          if (r_pv) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_shift_done) begin
            r_state <= ST_LATCH;
            r_lat   <= 1'b1;
            r_addr  <= r_act_addr;
          end
        end
        ST_LATCH: begin
          r_state <= ST_SHOW;
          r_oe    <= 1'b0;
          r_bcm   <= BW'(1);
          // Prefetch the next pair while the longest plane is lit.
          r_ready <= w_last_plane & ~r_pv & ~stream.data_valid;
        end
        ST_SHOW: begin
          if (w_bcm_end) begin
            r_oe    <= 1'b1;
            r_bcm   <= '0;
            r_state <= w_start ? ST_SHIFT : ST_WAIT;
          end else begin
            r_bcm <= r_bcm + BW'(1);
          end
        end
        default: begin
          r_state <= ST_REQ;
          r_oe    <= 1'b1;
        end
      endcase
    end
  end

  assign stream.hub75_ready = r_ready;
  assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = w_rgb;
  assign hub_clk  = w_hub_clk;
  assign hub_lat  = r_lat;
  assign hub_oe   = r_oe;
  assign hub_addr = r_addr;

endmodule

`default_nettype wire
